// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_pkg
//  Description : Shared maze tile codes, collision codes and grid geometry
//                used by the collision detector, pill counter and score logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

    // Grid geometry: 32x32 tiles, address = {row, col}
    localparam int c_COORD_W = 5;
    localparam int c_ADDR_W  = 2 * c_COORD_W;

    // Maze RAM tile codes
    typedef enum logic [1:0] {
        TILE_EMPTY = 2'b00,
        TILE_WALL  = 2'b01,
        TILE_PILL  = 2'b10,
        TILE_POWER = 2'b11
    } tile_t;

    // Collision classification codes
    typedef enum logic [3:0] {
        COLL_NONE  = 4'b0000,
        COLL_WALL  = 4'b0001,
        COLL_PILL  = 4'b0010,
        COLL_POWER = 4'b0100,
        COLL_GHOST = 4'b0110
    } collision_t;

endpackage : pacman_pkg
`default_nettype wire

// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : collision_detector
//  Description : Classifies the tile pacman has just entered (ghost, wall,
//                pill, power pellet or empty), clears eaten tiles in the maze
//                RAM and tracks the number of edible tiles remaining.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_detector
    import pacman_pkg::*;
#(
    parameter logic [7:0] PILL_TOTAL = 8'd150
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  move_strobe,
    input  logic [c_COORD_W-1:0]  pac_x,
    input  logic [c_COORD_W-1:0]  pac_y,
    input  logic [c_COORD_W-1:0]  ghost_x,
    input  logic [c_COORD_W-1:0]  ghost_y,
    output logic [c_ADDR_W-1:0]   maze_rd_addr,
    input  logic [1:0]            maze_rd_data,
    output logic                  maze_wr_en,
    output logic [c_ADDR_W-1:0]   maze_wr_addr,
    output logic [1:0]            maze_wr_data,
    output logic [3:0]            collision_type,
    output logic                  busy,
    output logic [7:0]            pills_left,
    output logic                  level_clear
);

    // READ waits out the RAM's registered read; EVAL sees valid data and
    // registers the result, so the OUT-cycle pulse is consumed downstream
    // at the third edge after the strobe was sampled.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EVAL = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                 r_state,      w_state_nxt;
    logic [c_ADDR_W-1:0]    r_rd_addr,    w_rd_addr_nxt;
    logic [c_ADDR_W-1:0]    r_ghost_addr, w_ghost_addr_nxt;
    logic [3:0]             r_coll,       w_coll_nxt;
    logic                   r_wr_en,      w_wr_en_nxt;
    logic                   r_lvl_clr,    w_lvl_clr_nxt;
    logic [7:0]             r_pills,      w_pills_nxt;

    // State register and registered outputs; reset aborts any lookup
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_ghost_addr <= '0;
            r_coll       <= COLL_NONE;
            r_wr_en      <= 1'b0;
            r_lvl_clr    <= 1'b0;
            r_pills      <= PILL_TOTAL;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_ghost_addr <= w_ghost_addr_nxt;
            r_coll       <= w_coll_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_lvl_clr    <= w_lvl_clr_nxt;
            r_pills      <= w_pills_nxt;
        end
    end

    // Next-state, classification and pill bookkeeping
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_addr_nxt    = r_rd_addr;
        w_ghost_addr_nxt = r_ghost_addr;
        w_coll_nxt       = COLL_NONE;
        w_wr_en_nxt      = 1'b0;
        w_lvl_clr_nxt    = 1'b0;
        w_pills_nxt      = r_pills;

        case (r_state)
            S_IDLE: begin
                if (move_strobe) begin
                    w_rd_addr_nxt    = {pac_y, pac_x};
                    w_ghost_addr_nxt = {ghost_y, ghost_x};
                    w_state_nxt      = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_state_nxt = S_OUT;
                if (r_ghost_addr == r_rd_addr) begin
                    // Ghost wins over the tile; nothing is eaten
                    w_coll_nxt = COLL_GHOST;
                end else begin
                    case (maze_rd_data)
                        TILE_EMPTY: w_coll_nxt = COLL_NONE;
                        TILE_WALL:  w_coll_nxt = COLL_WALL;
                        TILE_PILL,
                        TILE_POWER: begin
                            w_coll_nxt  = (maze_rd_data == TILE_PILL) ? COLL_PILL : COLL_POWER;
                            w_wr_en_nxt = 1'b1;
                            // Saturate at zero; the tile is still cleared
                            if (r_pills != 8'd0) begin
                                w_pills_nxt = r_pills - 8'd1;
                            end
                            w_lvl_clr_nxt = (r_pills == 8'd1);
                        end
                        default:    w_coll_nxt = COLL_NONE;
                    endcase
                end
            end
            S_OUT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign maze_rd_addr   = r_rd_addr;
    assign maze_wr_addr   = r_rd_addr;
    assign maze_wr_data   = TILE_EMPTY;
    assign maze_wr_en     = r_wr_en;
    assign collision_type = r_coll;
    assign level_clear    = r_lvl_clr;
    assign pills_left     = r_pills;
    assign busy           = (r_state != S_IDLE);

endmodule : collision_detector
`default_nettype wire
